// File: rtl/snn_core_param.sv
// Parametrised single-layer spiking classifier core.
// Streams binary pixels and signed weights, accumulates saturating scores, reports argmax.
module snn_core_param #(
    parameter int N_IN     = 784,
    parameter int N_OUT    = 10,
    parameter int WEIGHT_W = 8,
    parameter int ACC_W    = 16,
    parameter int IN_AW    = $clog2(N_IN),
    parameter int W_AW     = $clog2(N_IN * N_OUT),
    parameter int CLASS_W  = $clog2(N_OUT)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic [IN_AW-1:0]           addr_input_unit,
    input  logic                       q_input,
    output logic [W_AW-1:0]            addr_weight,
    input  logic signed [WEIGHT_W-1:0] q_weight,
    output logic [CLASS_W-1:0]         digit,
    output logic signed [ACC_W-1:0]    max_score
);

    // Sum width wide enough that a single add can never overflow
    localparam int SW = ((ACC_W > WEIGHT_W) ? ACC_W : WEIGHT_W) + 1;

    localparam logic [IN_AW-1:0]   I_LAST = IN_AW'(N_IN - 1);
    localparam logic [CLASS_W-1:0] J_LAST = CLASS_W'(N_OUT - 1);
    localparam logic [W_AW-1:0]    W_STEP = W_AW'(N_IN);

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_COMPARE,
        S_FINISH
    } state_t;

    state_t                     state;
    logic [IN_AW-1:0]           i;
    logic [CLASS_W-1:0]         j;
    logic [W_AW-1:0]            base;
    logic signed [ACC_W-1:0]    acc;
    logic signed [ACC_W-1:0]    best;
    logic [CLASS_W-1:0]         idx;

    logic signed [WEIGHT_W-1:0] term;
    logic signed [ACC_W-1:0]    acc_next;
    logic                       upd;

    // Add a sign-extended weight and clamp instead of wrapping
    function automatic logic signed [ACC_W-1:0] sat_add(
        input logic signed [ACC_W-1:0]    a,
        input logic signed [WEIGHT_W-1:0] b
    );
        logic [SW-1:0]       s;
        logic [SW-ACC_W:0]   top;
        s = {{(SW-ACC_W){a[ACC_W-1]}}, a}
          + {{(SW-WEIGHT_W){b[WEIGHT_W-1]}}, b};
        top = s[SW-1:ACC_W-1];
        if (top == '0 || top == '1) begin
            sat_add = s[ACC_W-1:0];
        end else if (s[SW-1]) begin
            sat_add = ACC_MIN;
        end else begin
            sat_add = ACC_MAX;
        end
    endfunction

    // Term for the pair returned this cycle, and the compare decision
    always_comb begin
        term     = q_input ? q_weight : '0;
        acc_next = sat_add(acc, term);
        upd      = (j == '0) || (acc_next > best);
    end

    // Control FSM, datapath registers and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            i               <= '0;
            j               <= '0;
            base            <= '0;
            acc             <= '0;
            best            <= '0;
            idx             <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            addr_input_unit <= '0;
            addr_weight     <= '0;
            digit           <= '0;
            max_score       <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        state           <= S_ISSUE;
                        busy            <= 1'b1;
                        i               <= '0;
                        j               <= '0;
                        base            <= '0;
                        acc             <= '0;
                        addr_input_unit <= '0;
                        addr_weight     <= '0;
                    end
                end
                S_ISSUE: begin
                    // Data for address i-1 arrives while address i is driven
                    if (i != '0) begin
                        acc <= acc_next;
                    end
                    if (i == I_LAST) begin
                        state           <= S_COMPARE;
                        addr_input_unit <= '0;
                        addr_weight     <= '0;
                    end else begin
                        i               <= i + IN_AW'(1);
                        addr_input_unit <= i + IN_AW'(1);
                        addr_weight     <= addr_weight + W_AW'(1);
                    end
                end
                S_COMPARE: begin
                    acc <= '0;
                    i   <= '0;
                    j   <= j + CLASS_W'(1);
                    if (upd) begin
                        best <= acc_next;
                        idx  <= j;
                    end
                    if (j == J_LAST) begin
                        state     <= S_FINISH;
                        done      <= 1'b1;
                        digit     <= upd ? j : idx;
                        max_score <= upd ? acc_next : best;
                    end else begin
                        state       <= S_ISSUE;
                        base        <= base + W_STEP;
                        addr_weight <= base + W_STEP;
                    end
                end
                S_FINISH: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
